// File: rtl/fxp_to_fp_block.sv
// -----------------------------------------------------------------------------
// fxp_to_fp_block
//
// Converts a frame of unsigned fixed-point words (exp/LUT stage results) into
// IEEE-754 single-precision values for the FP divide/normalise stage of the
// softmax pipeline. Input words are buffered as they arrive, so the producer
// can burst one word per cycle. A three-state FSM turns each buffered word
// into a float in three cycles.
//
// Input format : unsigned Q(32-frac_bits).frac_bits
// Output format: IEEE-754 single, sign always 0. The mantissa is truncated
//                (round toward zero). No denormals. Zero maps to +0.0.
//
// Ports
//   clock_i      in   1          clock, rising edge
//   reset_n_i    in   1          asynchronous active-low reset
//   fxp_i        in   data_size  unsigned fixed-point input word
//   fxp_valid_i  in   1          fxp_i valid this cycle (no backpressure)
//   fp_o         out  data_size  IEEE-754 single result
//   fp_valid_o   out  1          one-cycle pulse, fp_o valid
//   fp_done_o    out  1          sticky: whole frame emitted, held until reset
// -----------------------------------------------------------------------------
module fxp_to_fp_block #(
    parameter int data_size      = 32,
    parameter int number_of_data = 10,
    parameter int frac_bits      = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic [data_size-1:0] fxp_i,
    input  logic                 fxp_valid_i,
    output logic [data_size-1:0] fp_o,
    output logic                 fp_valid_o,
    output logic                 fp_done_o
);

    // Buffer address width. A one-entry frame still needs a one-bit index.
    localparam int addr_w = (number_of_data > 1) ? $clog2(number_of_data) : 1;

    localparam logic [7:0] frame_len = 8'(number_of_data);

    // 127 - frac_bits: the biased exponent of a word whose leading one sits at
    // bit 0. Adding the leading-one index gives the final biased exponent.
    localparam logic [8:0] exp_bias_adj = 9'(127 - frac_bits);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2
    } state_t;

    state_t state_reg;

    // ------------------------------------------------------------------
    // Frame buffer. It has no reset, so it can map onto block RAM. After a
    // reset the stale contents are never read, because rd_cnt cannot pass
    // wr_cnt.
    // ------------------------------------------------------------------
    logic [data_size-1:0] buf_mem [0:number_of_data-1];
    logic [7:0]           wr_cnt_reg;
    logic [7:0]           rd_cnt_reg;
    logic                 wr_en;
    logic                 load_work;
    logic [addr_w-1:0]    wr_idx;
    logic [addr_w-1:0]    rd_idx;

    assign wr_en  = fxp_valid_i && (wr_cnt_reg < frame_len);
    assign wr_idx = wr_cnt_reg[addr_w-1:0];
    assign rd_idx = rd_cnt_reg[addr_w-1:0];

    // A word is fetched only while idle. Once the frame is done, rd_cnt has
    // caught up with wr_cnt and the FSM stays parked in IDLE.
    assign load_work = (state_reg == IDLE) && !fp_done_o && (rd_cnt_reg < wr_cnt_reg);

    always_ff @(posedge clock_i) begin
        if (wr_en) begin
            buf_mem[wr_idx] <= fxp_i;
        end
    end

    // Registered read port. This register is the working operand of the
    // conversion. It loads only when the FSM leaves IDLE, so it needs no reset.
    logic [data_size-1:0] work_reg;

    always_ff @(posedge clock_i) begin
        if (load_work) begin
            work_reg <= buf_mem[rd_idx];
        end
    end

    // Write counter. Words beyond the frame length are dropped silently.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_cnt_reg <= 8'd0;
        end else if (wr_en) begin
            wr_cnt_reg <= wr_cnt_reg + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Leading-one detector.
    // above[k] is set when any bit at position >= k is set. A bit is the
    // leading one when it is set and nothing above it is set. That gives a
    // one-hot vector, which is then encoded into a 5-bit index.
    // ------------------------------------------------------------------
    logic [data_size:1]   above;
    logic [data_size-1:0] lead_onehot;
    logic [4:0]           lead_pos;

    assign above[data_size] = 1'b0;

    generate
        for (genvar gi = 1; gi < data_size; gi++) begin : g_above
            assign above[gi] = above[gi+1] | work_reg[gi];
        end
        for (genvar gi = 0; gi < data_size; gi++) begin : g_lead
            assign lead_onehot[gi] = work_reg[gi] & ~above[gi+1];
        end
    endgenerate

    always_comb begin
        lead_pos = 5'd0;
        for (int i = 0; i < data_size; i++) begin
            if (lead_onehot[i]) begin
                lead_pos = 5'(i);
            end
        end
    end

    // Normalise: shift the leading one up to bit 31. The 23 bits below it
    // are the stored mantissa. Lower bits are discarded, which truncates.
    logic [4:0]  shift_amt;
    logic [22:0] mant_next;

    assign shift_amt = 5'd31 - lead_pos;
    assign mant_next = 23'((work_reg << shift_amt) >> 8);

    // ------------------------------------------------------------------
    // Conversion FSM with registered outputs.
    // ------------------------------------------------------------------
    logic [4:0]  p_reg;
    logic        z_reg;
    logic [22:0] mant_reg;
    logic [7:0]  exp_field;

    assign exp_field = 8'(exp_bias_adj + {4'b0000, p_reg});

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg  <= IDLE;
            rd_cnt_reg <= 8'd0;
            p_reg      <= 5'd0;
            z_reg      <= 1'b0;
            mant_reg   <= 23'd0;
            fp_o       <= '0;
            fp_valid_o <= 1'b0;
            fp_done_o  <= 1'b0;
        end else begin
            // The valid output is a single-cycle pulse. PACK overrides this default.
            fp_valid_o <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (load_work) begin
                        state_reg <= NORM;
                    end
                end

                NORM: begin
                    p_reg     <= lead_pos;
                    z_reg     <= ~|work_reg;
                    mant_reg  <= mant_next;
                    state_reg <= PACK;
                end

                PACK: begin
                    fp_o       <= z_reg ? '0 : {1'b0, exp_field, mant_reg};
                    fp_valid_o <= 1'b1;
                    rd_cnt_reg <= rd_cnt_reg + 8'd1;
                    // Done rises on the same edge as the last result of the frame.
                    if ((rd_cnt_reg + 8'd1) == frame_len) begin
                        fp_done_o <= 1'b1;
                    end
                    state_reg  <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
